alu_share_ctrl: RTL

Shared-ALU controller: arbitrates two requesters (e.g. datapath issue port and an address/branch helper) onto one external 64-bit combinational ALU. Accepts one operation at a time through a valid/ready handshake, selects round-robin, drives the ALU from registered operands, captures result and zero flag, and returns them on the owner's response channel. Sits between the requesters and the ALU's `a`/`b`/`ALUControl`/`result`/`zero` pins.

---
 rtl/alu_share_ctrl_pkg.sv | 26 ++
 rtl/alu_share_ctrl_if.sv | 32 +++
 rtl/alu_share_ctrl_rr_arb2.sv | 12 +
 rtl/alu_share_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared types for the shared-ALU controller: FSM states, legal ALU opcodes, opcode check.
// No logic of its own; imported by the controller.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester, response and ALU pin bundle; slave = the controller, master = requesters plus ALU.
// Valid/ready on both request and response channels.
interface alu_share_ctrl_if #(parameter int WIDTH = 64);

  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_err;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_ctl;
  logic             alu_zero;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctl, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctl, busy
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin picker, combinational, zero latency; one-hot grant, none when idle.
// On contention the input that was not served last wins.
module rr_arb2 (
  input  logic [1:0] i_vld,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  assign o_gnt[0] = i_vld[0] & (~i_vld[1] |  i_last);
  assign o_gnt[1] = i_vld[1] & (~i_vld[0] | ~i_last);

endmodule

// File: rtl/alu_share_ctrl.sv
// Shared-ALU controller: accept (IDLE) -> drive ALU (EXEC) -> respond (RESP), 3 cycles minimum per op.
// Requests stall while busy; RESP holds until the owner's ready. ALU_SHARE_OPCHECK_EN enables illegal-op trapping.
module alu_share_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  alu_share_ctrl_if.slave bus
);
  import alu_share_pkg::*;

  state_e           r_state, w_state_nxt;
  logic             r_last, r_owner;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [3:0]       r_op;
  logic             r_zero, r_err;
  logic [1:0]       w_gnt;
  logic             w_accept, w_rsp_done, w_legal;

  rr_arb2 u_arb (
    .i_vld  ({bus.req1_valid, bus.req0_valid}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_accept   = (r_state == IDLE) && (w_gnt != 2'b00);
  assign w_rsp_done = (r_state == RESP) && (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

`ifdef ALU_SHARE_OPCHECK_EN
  assign w_legal = op_legal(r_op);
`else
  assign w_legal = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_ctl    = 4'b0000;
    case (r_state)
      IDLE: begin
        bus.req0_ready = w_gnt[0];
        bus.req1_ready = w_gnt[1];
        if (w_accept) w_state_nxt = EXEC;
      end
      EXEC: begin
        // An illegal op never reaches the ALU pins
        if (w_legal) begin
          bus.alu_a   = r_a;
          bus.alu_b   = r_b;
          bus.alu_ctl = r_op;
        end
        w_state_nxt = RESP;
      end
      RESP: begin
        bus.rsp0_valid = ~r_owner;
        bus.rsp1_valid =  r_owner;
        if (w_rsp_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 4'b0000;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_gnt[1];
        r_last  <= w_gnt[1];
        r_a     <= w_gnt[1] ? bus.req1_a  : bus.req0_a;
        r_b     <= w_gnt[1] ? bus.req1_b  : bus.req0_b;
        r_op    <= w_gnt[1] ? bus.req1_op : bus.req0_op;
      end
      if (r_state == EXEC) begin
        r_result <= w_legal ? bus.alu_result : '1;
        r_zero   <= w_legal & bus.alu_zero;
        r_err    <= ~w_legal;
      end
    end
  end

  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign bus.rsp_err    = r_err;
  assign bus.busy       = (r_state != IDLE);

endmodule
